// File: rtl/rvfi_pkg.sv
// rvfi_pkg: shared types for the RVFI commit packer.
// Holds the tracer record and the in-flight entry layout.
package rvfi_pkg;

  localparam int XLEN  = 64;
  localparam int VLEN  = 64;
  localparam int MASKW = XLEN / 8;

  typedef struct packed {
    logic             valid;
    logic [63:0]      order;
    logic [31:0]      insn;
    logic             trap;
    logic [XLEN-1:0]  cause;
    logic [1:0]       mode;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_wdata;
    logic [VLEN-1:0]  pc_rdata;
    logic [XLEN-1:0]  mem_addr;
    logic [MASKW-1:0] mem_rmask;
    logic [MASKW-1:0] mem_wmask;
    logic [XLEN-1:0]  mem_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    logic [VLEN-1:0]  pc;
    logic [31:0]      insn;
    logic [1:0]       mode;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_wdata;
    logic [XLEN-1:0]  mem_addr;
    logic [MASKW-1:0] mem_rmask;
    logic [MASKW-1:0] mem_wmask;
    logic [XLEN-1:0]  mem_wdata;
    logic             trap;
    logic [XLEN-1:0]  cause;
    logic             valid;
    logic             done;
  } rvfi_entry_t;

  // x0 writes carry no data in the trace
  function automatic logic [XLEN-1:0] rd_data(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] data
  );
    return (addr == 5'd0) ? '0 : data;
  endfunction

endpackage

// File: rtl/rvfi_retire_sel.sv
// rvfi_retire_sel: picks the in-order retire prefix.
// Builds one trace record per port from the head window.
module rvfi_retire_sel
  import rvfi_pkg::*;
#(
  parameter int NR = 2,
  parameter int CW = $clog2(NR + 1)
) (
  input  rvfi_entry_t       win_i [NR],
  input  logic [63:0]       order_i,
  output logic [CW-1:0]     cnt_o,
  output logic [CW-1:0]     nvalid_o,
  output logic              trap_o,
  output logic [CW-1:0]     trap_pos_o,
  output rvfi_instr_t       rec_o [NR]
);

  // Walk the window; stop at the first not-done entry or after a trap
  always_comb begin
    logic stop;
    stop       = 1'b0;
    cnt_o      = '0;
    nvalid_o   = '0;
    trap_o     = 1'b0;
    trap_pos_o = '0;
    for (int k = 0; k < NR; k++) begin
      rec_o[k] = '0;
      if (!stop && win_i[k].valid && win_i[k].done) begin
        cnt_o = cnt_o + CW'(1);
        if (win_i[k].trap) begin
          trap_o            = 1'b1;
          trap_pos_o        = CW'(k);
          stop              = 1'b1;
          rec_o[k].trap     = 1'b1;
          rec_o[k].cause    = win_i[k].cause;
          rec_o[k].pc_rdata = win_i[k].pc;
          rec_o[k].insn     = win_i[k].insn;
          rec_o[k].mode     = win_i[k].mode;
        end else begin
          rec_o[k].valid     = 1'b1;
          rec_o[k].order     = order_i + 64'(nvalid_o);
          rec_o[k].pc_rdata  = win_i[k].pc;
          rec_o[k].insn      = win_i[k].insn;
          rec_o[k].mode      = win_i[k].mode;
          rec_o[k].rd_addr   = win_i[k].rd_addr;
          rec_o[k].rd_wdata  = rd_data(win_i[k].rd_addr,
                                       win_i[k].rd_wdata);
          rec_o[k].mem_addr  = win_i[k].mem_addr;
          rec_o[k].mem_rmask = win_i[k].mem_rmask;
          rec_o[k].mem_wmask = win_i[k].mem_wmask;
          rec_o[k].mem_wdata = win_i[k].mem_wdata;
          nvalid_o = nvalid_o + CW'(1);
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_packer.sv
// rvfi_commit_packer: in-order retire buffer feeding RVFI.
// Dispatch in order, complete by tag, retire up to N per cycle.
module rvfi_commit_packer
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8,
  localparam int TAG_W          = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  disp_valid_i,
  output logic                  disp_ready_o,
  input  logic [VLEN-1:0]       disp_pc_i,
  input  logic [31:0]           disp_insn_i,
  input  logic [1:0]            disp_mode_i,
  output logic [TAG_W-1:0]      disp_tag_o,
  input  logic                  wb_valid_i,
  input  logic [TAG_W-1:0]      wb_tag_i,
  input  logic [4:0]            wb_rd_addr_i,
  input  logic [XLEN-1:0]       wb_rd_wdata_i,
  input  logic [XLEN-1:0]       wb_mem_addr_i,
  input  logic [XLEN/8-1:0]     wb_mem_rmask_i,
  input  logic [XLEN/8-1:0]     wb_mem_wmask_i,
  input  logic [XLEN-1:0]       wb_mem_wdata_i,
  input  logic                  wb_trap_i,
  input  logic [XLEN-1:0]       wb_cause_i,
  input  logic                  flush_i,
  output rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_o
);

  localparam int NR = NR_COMMIT_PORTS;
  localparam int CW = $clog2(NR + 1);

  typedef logic [TAG_W:0] ptr_t;

  rvfi_entry_t ent_q [DEPTH];
  rvfi_entry_t ent_d [DEPTH];
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic [63:0] order_q, order_d;
  rvfi_instr_t [NR-1:0] rvfi_q;

  rvfi_entry_t win [NR];
  rvfi_instr_t rec [NR];
  logic [CW-1:0] ret_cnt;
  logic [CW-1:0] ret_nvalid;
  logic [CW-1:0] trap_pos;
  logic          ret_trap;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic full;
  logic disp_fire;
  logic wb_ok;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign full     = (head_idx == tail_idx) &&
                    (head_q[TAG_W] != tail_q[TAG_W]);

  assign disp_ready_o = !rst_i && !full && !flush_i;
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign disp_tag_o   = tail_idx;
  assign wb_ok        = ent_q[wb_tag_i].valid &&
                        !ent_q[wb_tag_i].done;
  assign rvfi_o       = rvfi_q;

  // Gather the NR oldest slots starting at head
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      win[k] = ent_q[TAG_W'(head_idx + TAG_W'(k))];
    end
  end

  rvfi_retire_sel #(
    .NR (NR),
    .CW (CW)
  ) u_sel (
    .win_i      (win),
    .order_i    (order_q),
    .cnt_o      (ret_cnt),
    .nvalid_o   (ret_nvalid),
    .trap_o     (ret_trap),
    .trap_pos_o (trap_pos),
    .rec_o      (rec)
  );

  // Pointer and order next state; flush and trap collapse tail
  always_comb begin
    head_d  = head_q + ptr_t'(ret_cnt);
    order_d = order_q + 64'(ret_nvalid);
    if (flush_i) begin
      tail_d = head_d;
    end else if (ret_trap) begin
      tail_d = head_q + ptr_t'(trap_pos) + ptr_t'(1);
    end else begin
      tail_d = tail_q + ptr_t'(disp_fire);
    end
  end

  // Entry array next state: retire clear, squash, complete, dispatch
  always_comb begin
    logic [TAG_W-1:0] idx;
    idx   = '0;
    ent_d = ent_q;
    if (flush_i || ret_trap) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (CW'(k) < ret_cnt) begin
          idx = TAG_W'(head_idx + TAG_W'(k));
          ent_d[idx].valid = 1'b0;
          ent_d[idx].done  = 1'b0;
        end
      end
      if (wb_valid_i && wb_ok) begin
        ent_d[wb_tag_i].rd_addr   = wb_rd_addr_i;
        ent_d[wb_tag_i].rd_wdata  = wb_rd_wdata_i;
        ent_d[wb_tag_i].mem_addr  = wb_mem_addr_i;
        ent_d[wb_tag_i].mem_rmask = wb_mem_rmask_i;
        ent_d[wb_tag_i].mem_wmask = wb_mem_wmask_i;
        ent_d[wb_tag_i].mem_wdata = wb_mem_wdata_i;
        ent_d[wb_tag_i].trap      = wb_trap_i;
        ent_d[wb_tag_i].cause     = wb_cause_i;
        ent_d[wb_tag_i].done      = 1'b1;
      end
      if (disp_fire) begin
        ent_d[tail_idx]       = '0;
        ent_d[tail_idx].pc    = disp_pc_i;
        ent_d[tail_idx].insn  = disp_insn_i;
        ent_d[tail_idx].mode  = disp_mode_i;
        ent_d[tail_idx].valid = 1'b1;
      end
    end
  end

  // Head, tail and retire order counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      order_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      order_q <= order_d;
    end
  end

  // In-flight entry storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  // Registered trace records
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvfi_q <= '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        rvfi_q[k] <= rec[k];
      end
    end
  end

  // A completion must target a live, not-yet-completed entry
  wb_target_live: assert property (
    @(posedge clk_i) disable iff (rst_i)
    wb_valid_i |-> wb_ok
  );

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// tb_rvfi_commit_packer: directed and random checks
// against a queue-based program-order model.
module tb_rvfi_commit_packer;
  import rvfi_pkg::*;

  localparam int NP = 2;
  localparam int D  = 8;
  localparam int TW = $clog2(D);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              disp_valid_i;
  logic              disp_ready_o;
  logic [VLEN-1:0]   disp_pc_i;
  logic [31:0]       disp_insn_i;
  logic [1:0]        disp_mode_i;
  logic [TW-1:0]     disp_tag_o;
  logic              wb_valid_i;
  logic [TW-1:0]     wb_tag_i;
  logic [4:0]        wb_rd_addr_i;
  logic [XLEN-1:0]   wb_rd_wdata_i;
  logic [XLEN-1:0]   wb_mem_addr_i;
  logic [XLEN/8-1:0] wb_mem_rmask_i;
  logic [XLEN/8-1:0] wb_mem_wmask_i;
  logic [XLEN-1:0]   wb_mem_wdata_i;
  logic              wb_trap_i;
  logic [XLEN-1:0]   wb_cause_i;
  logic              flush_i;
  rvfi_instr_t [NP-1:0] rvfi_o;

  rvfi_commit_packer #(
    .NR_COMMIT_PORTS (NP),
    .DEPTH           (D)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .disp_valid_i   (disp_valid_i),
    .disp_ready_o   (disp_ready_o),
    .disp_pc_i      (disp_pc_i),
    .disp_insn_i    (disp_insn_i),
    .disp_mode_i    (disp_mode_i),
    .disp_tag_o     (disp_tag_o),
    .wb_valid_i     (wb_valid_i),
    .wb_tag_i       (wb_tag_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_rd_wdata_i  (wb_rd_wdata_i),
    .wb_mem_addr_i  (wb_mem_addr_i),
    .wb_mem_rmask_i (wb_mem_rmask_i),
    .wb_mem_wmask_i (wb_mem_wmask_i),
    .wb_mem_wdata_i (wb_mem_wdata_i),
    .wb_trap_i      (wb_trap_i),
    .wb_cause_i     (wb_cause_i),
    .flush_i        (flush_i),
    .rvfi_o         (rvfi_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Program-order model: queue of in-flight instructions
  typedef struct {
    int          tag;
    bit          done;
    bit          trap;
    logic [63:0] cause;
    rvfi_instr_t r;
  } ment_t;

  ment_t       q[$];
  int          ntag = 0;
  logic [63:0] ord  = '0;

  task automatic clr();
    disp_valid_i   = 1'b0;
    disp_pc_i      = '0;
    disp_insn_i    = '0;
    disp_mode_i    = '0;
    wb_valid_i     = 1'b0;
    wb_tag_i       = '0;
    wb_rd_addr_i   = '0;
    wb_rd_wdata_i  = '0;
    wb_mem_addr_i  = '0;
    wb_mem_rmask_i = '0;
    wb_mem_wmask_i = '0;
    wb_mem_wdata_i = '0;
    wb_trap_i      = 1'b0;
    wb_cause_i     = '0;
    flush_i        = 1'b0;
  endtask

  // One clock: check handshake, step model, check records
  task automatic cyc();
    rvfi_instr_t ex [NP];
    int  n;
    int  ht;
    bit  tr;
    bit  rdy;
    ment_t m;
    #1;
    rdy = (q.size() < D) && !flush_i;
    chk("ready", disp_ready_o, rdy);
    chk("tag", disp_tag_o, ntag);
    for (int k = 0; k < NP; k++) ex[k] = '0;
    n  = 0;
    tr = 0;
    while (!tr && n < NP && n < q.size() && q[n].done) begin
      if (q[n].trap) begin
        ex[n].trap     = 1'b1;
        ex[n].cause    = q[n].cause;
        ex[n].pc_rdata = q[n].r.pc_rdata;
        ex[n].insn     = q[n].r.insn;
        ex[n].mode     = q[n].r.mode;
        tr = 1;
      end else begin
        ex[n]       = q[n].r;
        ex[n].valid = 1'b1;
        ex[n].order = ord;
        if (ex[n].rd_addr == 0) ex[n].rd_wdata = '0;
        ord++;
      end
      n++;
    end
    ht = (q.size() > 0) ? q[0].tag : ntag;
    repeat (n) void'(q.pop_front());
    if (tr || flush_i) begin
      q.delete();
      ntag = (ht + n) % D;
    end else begin
      if (wb_valid_i) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(wb_tag_i) && !q[i].done) begin
            q[i].done        = 1;
            q[i].trap        = wb_trap_i;
            q[i].cause       = wb_cause_i;
            q[i].r.rd_addr   = wb_rd_addr_i;
            q[i].r.rd_wdata  = wb_rd_wdata_i;
            q[i].r.mem_addr  = wb_mem_addr_i;
            q[i].r.mem_rmask = wb_mem_rmask_i;
            q[i].r.mem_wmask = wb_mem_wmask_i;
            q[i].r.mem_wdata = wb_mem_wdata_i;
          end
        end
      end
      if (disp_valid_i && rdy) begin
        m.tag        = ntag;
        m.done       = 0;
        m.trap       = 0;
        m.cause      = '0;
        m.r          = '0;
        m.r.pc_rdata = disp_pc_i;
        m.r.insn     = disp_insn_i;
        m.r.mode     = disp_mode_i;
        q.push_back(m);
        ntag = (ntag + 1) % D;
      end
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NP; k++) chk("rvfi", rvfi_o[k], ex[k]);
  endtask

  task automatic do_reset();
    clr();
    rst_i        = 1'b1;
    disp_valid_i = 1'b1;
    repeat (2) begin
      #1;
      chk("rst_rdy", disp_ready_o, 0);
      for (int k = 0; k < NP; k++) chk("rst_rvfi", rvfi_o[k], 0);
      @(posedge clk_i);
    end
    #1;
    rst_i = 1'b0;
    clr();
    q.delete();
    ntag = 0;
    ord  = '0;
  endtask

  task automatic idle();
    clr();
    cyc();
  endtask

  task automatic dp(input logic [63:0] pc);
    clr();
    disp_valid_i = 1'b1;
    disp_pc_i    = pc;
    disp_insn_i  = $urandom;
    disp_mode_i  = 2'($urandom);
    cyc();
  endtask

  task automatic wbp(input int tag, input logic [4:0] rd,
                     input logic tr, input logic [63:0] cause);
    clr();
    wb_valid_i     = 1'b1;
    wb_tag_i       = TW'(tag);
    wb_rd_addr_i   = rd;
    wb_rd_wdata_i  = {$urandom, $urandom};
    wb_mem_addr_i  = {$urandom, $urandom};
    wb_mem_rmask_i = 8'($urandom);
    wb_mem_wmask_i = 8'($urandom);
    wb_mem_wdata_i = {$urandom, $urandom};
    wb_trap_i      = tr;
    wb_cause_i     = cause;
    cyc();
  endtask

  initial begin
    int cand[$];
    clr();
    do_reset();

    // out-of-order completion, in-order retire
    dp(64'h8000_0000);
    dp(64'h8000_0004);
    dp(64'h8000_0008);
    wbp(2, 5'd3, 1'b0, '0);
    wbp(0, 5'd4, 1'b0, '0);
    wbp(1, 5'd5, 1'b0, '0);
    chk("t1_p0pc", rvfi_o[0].pc_rdata, 64'h8000_0000);
    chk("t1_p1v", rvfi_o[1].valid, 0);
    idle();
    chk("t1_p0pc2", rvfi_o[0].pc_rdata, 64'h8000_0004);
    chk("t1_p1ord", rvfi_o[1].order, 2);
    idle();

    // fill, overflow attempt, drain two per cycle
    do_reset();
    for (int i = 0; i < D; i++) dp(64'h100 + 64'(4 * i));
    chk("t2_full", disp_ready_o, 0);
    dp(64'hBAD0);
    for (int i = D - 1; i >= 0; i--) wbp(i, 5'(i + 1), 1'b0, '0);
    repeat (5) idle();
    chk("t2_tag", disp_tag_o, 0);
    chk("t2_rdy", disp_ready_o, 1);

    // trap squashes younger entries
    do_reset();
    dp(64'h200);
    dp(64'h204);
    dp(64'h208);
    wbp(2, 5'd7, 1'b0, '0);
    wbp(1, 5'd6, 1'b1, 64'd2);
    wbp(0, 5'd5, 1'b0, '0);
    idle();
    chk("t3_p0v", rvfi_o[0].valid, 1);
    chk("t3_p0ord", rvfi_o[0].order, 0);
    chk("t3_p1trap", rvfi_o[1].trap, 1);
    chk("t3_p1v", rvfi_o[1].valid, 0);
    chk("t3_cause", rvfi_o[1].cause, 2);
    chk("t3_tag", disp_tag_o, 2);
    repeat (2) idle();

    // flush in the cycle the head retires
    do_reset();
    for (int i = 0; i < 4; i++) dp(64'h300 + 64'(4 * i));
    wbp(0, 5'd1, 1'b0, '0);
    clr();
    flush_i      = 1'b1;
    disp_valid_i = 1'b1;
    disp_pc_i    = 64'hDEAD;
    cyc();
    chk("t4_v", rvfi_o[0].valid, 1);
    dp(64'h400);
    wbp(1, 5'd2, 1'b0, '0);
    idle();
    chk("t4_ord", rvfi_o[0].order, 1);
    chk("t4_pc", rvfi_o[0].pc_rdata, 64'h400);

    // load and store field pass-through
    do_reset();
    dp(64'h500);
    dp(64'h504);
    clr();
    wb_valid_i     = 1'b1;
    wb_tag_i       = 0;
    wb_rd_addr_i   = 5'd5;
    wb_rd_wdata_i  = 64'h1234_5678_9ABC_DEF0;
    wb_mem_addr_i  = 64'h1000;
    wb_mem_rmask_i = 8'hFF;
    cyc();
    clr();
    wb_valid_i     = 1'b1;
    wb_tag_i       = 1;
    wb_rd_addr_i   = 5'd0;
    wb_rd_wdata_i  = 64'h5555;
    wb_mem_addr_i  = 64'h2000;
    wb_mem_wmask_i = 8'h0F;
    wb_mem_wdata_i = 64'hDEAD_BEEF;
    cyc();
    chk("t5_rd", rvfi_o[0].rd_addr, 5);
    chk("t5_rmask", rvfi_o[0].mem_rmask, 8'hFF);
    chk("t5_addr", rvfi_o[0].mem_addr, 64'h1000);
    idle();
    chk("t5_wmask", rvfi_o[0].mem_wmask, 8'h0F);
    chk("t5_wdata", rvfi_o[0].mem_wdata, 64'hDEAD_BEEF);
    chk("t5_rdw0", rvfi_o[0].rd_wdata, 0);

    // reset with entries in flight
    do_reset();
    for (int i = 0; i < 4; i++) dp(64'h600 + 64'(4 * i));
    wbp(1, 5'd3, 1'b0, '0);
    do_reset();
    dp(64'h700);
    wbp(0, 5'd4, 1'b0, '0);
    idle();
    chk("t6_v", rvfi_o[0].valid, 1);
    chk("t6_ord", rvfi_o[0].order, 0);
    chk("t6_pc", rvfi_o[0].pc_rdata, 64'h700);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      clr();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      disp_valid_i = ($urandom_range(0, 9) < 6);
      disp_pc_i    = {$urandom, $urandom};
      disp_insn_i  = $urandom;
      disp_mode_i  = 2'($urandom);
      flush_i      = ($urandom_range(0, 49) == 0);
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(q[i].tag);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid_i     = 1'b1;
        wb_tag_i       = TW'(cand[$urandom_range(0, cand.size() - 1)]);
        wb_rd_addr_i   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        wb_rd_wdata_i  = {$urandom, $urandom};
        wb_mem_addr_i  = {$urandom, $urandom};
        wb_mem_rmask_i = 8'($urandom);
        wb_mem_wmask_i = 8'($urandom);
        wb_mem_wdata_i = {$urandom, $urandom};
        wb_trap_i      = ($urandom_range(0, 11) == 0);
        wb_cause_i     = 64'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
